// File: rtl/dram_read_arbiter_pkg.sv
// Shared configuration for the DRAM read arbiter: bus widths, outstanding-read
// depth, requester-ID tag type and the address FSM state encoding.
package TauCfg;

    localparam int GLOBAL_ADDR_BW       = 32;
    localparam int DATA_BW              = 32;
    localparam int CACHE_SIZE           = 4;
    localparam int DRAM_ARB_OUTSTANDING = 4;
    localparam int DRAM_ARB_N_REQ       = 3;
    localparam int DRAM_ARB_RID_BW      = $clog2(DRAM_ARB_N_REQ);

    typedef logic [DRAM_ARB_RID_BW-1:0] dram_arb_rid_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_e;

    function automatic int wrap_inc(input int v, input int m);
        return (v + 1 >= m) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/dram_read_arbiter_tag_fifo.sv
// In-order FIFO of requester IDs for reads issued to DRAM but not yet returned.
// The caller never pushes when full and never pops when empty.
module tag_fifo
    import TauCfg::*;
#(
    parameter int  DEPTH  = DRAM_ARB_OUTSTANDING,
    parameter int  W      = DRAM_ARB_RID_BW,
    localparam int CNT_BW = $clog2(DEPTH + 1),
    localparam int PTR_BW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [W-1:0]      i_push_tag,
    input  logic              i_pop,
    output logic [W-1:0]      o_head,
    output logic [CNT_BW-1:0] o_count
);

    logic [W-1:0]      mem_q [DEPTH];
    logic [PTR_BW-1:0] wr_q, rd_q;
    logic [CNT_BW-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (i_push) wr_q <= PTR_BW'(wrap_inc(int'(wr_q), DEPTH));
            if (i_pop)  rd_q <= PTR_BW'(wrap_inc(int'(rd_q), DEPTH));
            case ({i_push, i_pop})
                2'b10:   cnt_q <= cnt_q + CNT_BW'(1);
                2'b01:   cnt_q <= cnt_q - CNT_BW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Tag storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge i_clk) begin
        if (i_push) mem_q[wr_q] <= i_push_tag;
    end

    assign o_head  = mem_q[rd_q];
    assign o_count = cnt_q;

endmodule

// File: rtl/dram_read_arbiter.sv
// Shares one DRAM read address/data port pair among N_REQ requesters.
// Define DRAM_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module dram_read_arbiter
    import TauCfg::*;
#(
    parameter int  N_REQ       = 3,
    parameter int  GBW         = GLOBAL_ADDR_BW,
    parameter int  DBW         = DATA_BW,
    parameter int  CSIZE       = CACHE_SIZE,
    parameter int  OUTSTANDING = DRAM_ARB_OUTSTANDING,
    localparam int RID_BW      = $clog2(N_REQ),
    localparam int OCNT_BW     = $clog2(OUTSTANDING + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       reqa_rdy,
    output logic [N_REQ-1:0]       reqa_ack,
    input  logic [N_REQ*GBW-1:0]   i_reqa,
    output logic                   dramra_rdy,
    input  logic                   dramra_ack,
    output logic [GBW-1:0]         o_dramra,
    input  logic                   dramrd_rdy,
    output logic                   dramrd_ack,
    input  logic [CSIZE*DBW-1:0]   i_dramrd,
    output logic [N_REQ-1:0]       rsp_rdy,
    input  logic [N_REQ-1:0]       rsp_ack,
    output logic [CSIZE*DBW-1:0]   o_rsp,
    output logic [OCNT_BW-1:0]     o_outstanding
);

    arb_state_e        state_q, state_d;
    logic [GBW-1:0]    addr_q, addr_d;
    logic [RID_BW-1:0] win;
    logic              grant;
    logic              can_grant;
    logic [RID_BW-1:0] head;
    logic [OCNT_BW-1:0] count;
    logic              nonempty;
    logic              head_ack;

`ifndef DRAM_ARB_FIXED_PRIO_EN
    logic [RID_BW-1:0] rr_q, rr_d;
`endif

    tag_fifo #(
        .DEPTH (OUTSTANDING),
        .W     (RID_BW)
    ) u_tag_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (grant),
        .i_push_tag (win),
        .i_pop      (dramrd_ack),
        .o_head     (head),
        .o_count    (count)
    );

    always_comb begin
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        win   = '0;
`ifdef DRAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && reqa_rdy[i]) begin
                win   = RID_BW'(i);
                found = 1'b1;
            end
        end
`else
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && reqa_rdy[idx]) begin
                win   = RID_BW'(idx);
                found = 1'b1;
            end
        end
`endif
    end

    // Full is judged on start-of-cycle occupancy; a same-cycle pop frees nothing.
    always_comb begin
        can_grant = ((state_q == ARB_IDLE) || dramra_ack) &&
                    (count < OCNT_BW'(OUTSTANDING));
        grant     = can_grant && (|reqa_rdy);
        state_d   = state_q;
        addr_d    = addr_q;
        for (int i = 0; i < N_REQ; i++) begin
            reqa_ack[i] = grant && (win == RID_BW'(i));
        end
        if (grant) begin
            state_d = ARB_ISSUE;
            addr_d  = i_reqa[int'(win)*GBW +: GBW];
        end else if (dramra_ack) begin
            state_d = ARB_IDLE;
        end
`ifndef DRAM_ARB_FIXED_PRIO_EN
        rr_d = grant ? RID_BW'(wrap_inc(int'(win), N_REQ)) : rr_q;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ARB_IDLE;
            addr_q  <= '0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
`ifndef DRAM_ARB_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    always_comb begin
        nonempty = (count != '0);
        head_ack = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_rdy[i] = dramrd_rdy && nonempty && (head == RID_BW'(i));
            head_ack   = head_ack | (rsp_ack[i] && (head == RID_BW'(i)));
        end
        dramrd_ack = nonempty && head_ack;
    end

    assign dramra_rdy    = (state_q == ARB_ISSUE);
    assign o_dramra      = addr_q;
    assign o_rsp         = i_dramrd;
    assign o_outstanding = count;

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Bench for dram_read_arbiter: directed scenarios with literal expectations,
// then randomized traffic against a queue-based reference model.
module tb_dram_read_arbiter;
    import TauCfg::*;

    localparam int N    = 3;
    localparam int GBW  = GLOBAL_ADDR_BW;
    localparam int DBW  = DATA_BW;
    localparam int CS   = CACHE_SIZE;
    localparam int OUTS = DRAM_ARB_OUTSTANDING;
    localparam int BW   = CS * DBW;
    localparam int OCB  = $clog2(OUTS + 1);

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   reqa_rdy, reqa_ack;
    logic [N*GBW-1:0] i_reqa;
    logic           dramra_rdy, dramra_ack;
    logic [GBW-1:0] o_dramra;
    logic           dramrd_rdy, dramrd_ack;
    logic [BW-1:0]  i_dramrd, o_rsp;
    logic [N-1:0]   rsp_rdy, rsp_ack;
    logic [OCB-1:0] o_outstanding;

    always #5 i_clk = ~i_clk;

    dram_read_arbiter #(
        .N_REQ(N), .GBW(GBW), .DBW(DBW), .CSIZE(CS), .OUTSTANDING(OUTS)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .reqa_rdy(reqa_rdy), .reqa_ack(reqa_ack), .i_reqa(i_reqa),
        .dramra_rdy(dramra_rdy), .dramra_ack(dramra_ack), .o_dramra(o_dramra),
        .dramrd_rdy(dramrd_rdy), .dramrd_ack(dramrd_ack), .i_dramrd(i_dramrd),
        .rsp_rdy(rsp_rdy), .rsp_ack(rsp_ack), .o_rsp(o_rsp),
        .o_outstanding(o_outstanding)
    );

    int vectors = 0;
    int errs    = 0;

    // Reference model: address-port occupancy, registered address, RR pointer, tag queue.
    bit             m_busy;
    logic [GBW-1:0] m_addr;
    int             m_rr;
    int             q[$];
    logic [N-1:0]   last_ack;
    logic           last_dack;
    logic [N-1:0]   one = 1;

    // Random-traffic source state.
    logic [N-1:0]   pend;
    logic [GBW-1:0] paddr [N];
    logic           beat_v;
    logic [BW-1:0]  beat;

    task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
`ifdef DRAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (reqa_rdy[i]) return i;
`else
        for (int k = 0; k < N; k++) if (reqa_rdy[(m_rr + k) % N]) return (m_rr + k) % N;
`endif
        return -1;
    endfunction

    function automatic logic [N-1:0] head_oh();
        return (q.size() > 0) ? (one << q[0]) : '0;
    endfunction

    task automatic model_check_update();
        int w;
        bit can, grant, pop;
        logic [N-1:0] e_ack, e_rsp;
        if (i_rst) begin
            m_busy = 0; m_addr = '0; m_rr = 0; q.delete();
            last_ack = '0; last_dack = 1'b0;
            return;
        end
        can   = (!m_busy || dramra_ack) && (q.size() < OUTS);
        w     = pick();
        grant = can && (w >= 0);
        e_ack = grant ? (one << w) : '0;
        e_rsp = (q.size() > 0 && dramrd_rdy) ? (one << q[0]) : '0;
        pop   = (q.size() > 0) && rsp_ack[q[0]];
        cmp("reqa_ack", reqa_ack, e_ack);
        cmp("dramra_rdy", dramra_rdy, m_busy);
        cmp("o_dramra", o_dramra, m_addr);
        cmp("rsp_rdy", rsp_rdy, e_rsp);
        cmp("dramrd_ack", dramrd_ack, pop);
        cmp("o_rsp", o_rsp, i_dramrd);
        cmp("o_outstanding", o_outstanding, q.size());
        last_ack  = e_ack;
        last_dack = pop;
        if (pop) void'(q.pop_front());
        if (grant) begin
            q.push_back(w);
            m_busy = 1;
            m_addr = i_reqa[w*GBW +: GBW];
            m_rr   = (w + 1) % N;
        end else if (dramra_ack) begin
            m_busy = 0;
        end
    endtask

    task automatic step();
        #1;
        model_check_update();
        @(negedge i_clk);
    endtask

    task automatic idle_inputs();
        reqa_rdy = '0; i_reqa = '0; dramra_ack = 0;
        dramrd_rdy = 0; i_dramrd = '0; rsp_ack = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst = 1;
        step();
        i_rst = 0;
    endtask

    task automatic rand_beat(output logic [BW-1:0] b);
        for (int k = 0; k < CS; k++) b[k*DBW +: DBW] = $urandom;
    endtask

    task automatic drain();
        for (int c = 0; c < 30 && (q.size() > 0 || m_busy); c++) begin
            reqa_rdy   = '0;
            dramra_ack = m_busy;
            dramrd_rdy = (q.size() > 0);
            rand_beat(i_dramrd);
            rsp_ack    = head_oh();
            step();
        end
        idle_inputs();
        #1 cmp("drain_outstanding", o_outstanding, 0);
        @(negedge i_clk);
    endtask

    task automatic drive_rand();
        i_rst = (($urandom % 300) == 0);
        for (int i = 0; i < N; i++) begin
            if (pend[i] && last_ack[i]) pend[i] = 0;
            if (i_rst) pend[i] = 0;
            else if (!pend[i] && ($urandom % 3) == 0) begin
                pend[i]  = 1;
                paddr[i] = $urandom;
            end
            i_reqa[i*GBW +: GBW] = paddr[i];
        end
        reqa_rdy = pend;
        if (beat_v && last_dack) beat_v = 0;
        if (!beat_v && ($urandom % 2) == 1) begin
            beat_v = 1;
            rand_beat(beat);
        end
        dramrd_rdy = beat_v;
        i_dramrd   = beat;
        dramra_ack = m_busy && !i_rst && (($urandom % 4) != 0);
        rsp_ack    = (dramrd_rdy && !i_rst && (($urandom % 4) != 0)) ? head_oh() : '0;
    endtask

    initial begin
        logic [BW-1:0] pat;
        logic [N-1:0]  exp_ack;
        idle_inputs();
        i_rst = 1;
        @(negedge i_clk);
        step();
        i_rst = 0;

        // Reset state.
        #1;
        cmp("rst_reqa_ack", reqa_ack, 0);
        cmp("rst_dramra_rdy", dramra_rdy, 0);
        cmp("rst_o_dramra", o_dramra, 0);
        cmp("rst_outstanding", o_outstanding, 0);
        cmp("rst_rsp_rdy", rsp_rdy, 0);
        cmp("rst_dramrd_ack", dramrd_ack, 0);
        step();

        // Single requester round trip.
        reqa_rdy = 3'b010; i_reqa[GBW +: GBW] = 32'h100; dramra_ack = 1;
        #1 cmp("single_ack", reqa_ack, 3'b010);
        step();
        reqa_rdy = '0;
        #1;
        cmp("single_ra_rdy", dramra_rdy, 1);
        cmp("single_addr", o_dramra, 32'h100);
        cmp("single_outst", o_outstanding, 1);
        step();
        dramra_ack = 0; dramrd_rdy = 1; pat = {32'hdead_beef, 32'h0123_4567, 32'h89ab_cdef, 32'h5a5a_a5a5};
        i_dramrd = pat; rsp_ack = 3'b010;
        #1;
        cmp("single_rsp_rdy", rsp_rdy, 3'b010);
        cmp("single_rsp_data", o_rsp, pat);
        cmp("single_rd_ack", dramrd_ack, 1);
        step();
        idle_inputs();
        step();

        // All three requesting continuously.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            reqa_rdy = 3'b111;
            for (int i = 0; i < N; i++) i_reqa[i*GBW +: GBW] = 32'h200 + i;
            dramra_ack = (k > 0);
            dramrd_rdy = (q.size() > 0);
            rsp_ack    = head_oh();
`ifdef DRAM_ARB_FIXED_PRIO_EN
            exp_ack = 3'b001;
`else
            exp_ack = 3'b001 << (k % 3);
`endif
            #1 cmp("grant_seq", reqa_ack, exp_ack);
            step();
        end
        drain();

        // Outstanding limit with the DRAM data side held off.
        do_reset();
        reqa_rdy = 3'b111;
        for (int i = 0; i < N; i++) i_reqa[i*GBW +: GBW] = 32'h300 + i;
        for (int k = 0; k < 4; k++) begin
            dramra_ack = (k > 0);
            step();
        end
        dramra_ack = 1;
        #1;
        cmp("full_outst", o_outstanding, 4);
        cmp("full_no_ack", reqa_ack, 0);
        step();
        dramra_ack = 0; dramrd_rdy = 1; rsp_ack = 3'b001;
        #1;
        cmp("pop_no_ack", reqa_ack, 0);
        cmp("pop_rd_ack", dramrd_ack, 1);
        step();
        dramrd_rdy = 0; rsp_ack = '0;
`ifdef DRAM_ARB_FIXED_PRIO_EN
        exp_ack = 3'b001;
`else
        exp_ack = 3'b010;
`endif
        #1;
        cmp("after_pop_outst", o_outstanding, 3);
        cmp("after_pop_ack", reqa_ack, exp_ack);
        step();
        drain();

        // Address stall, then reset mid-operation.
        do_reset();
        reqa_rdy = 3'b001; i_reqa[0 +: GBW] = 32'h400; i_reqa[GBW +: GBW] = 32'h500;
        #1 cmp("stall_first_ack", reqa_ack, 3'b001);
        step();
        reqa_rdy = 3'b010;
        for (int k = 0; k < 4; k++) begin
            #1;
            cmp("stall_ack", reqa_ack, 0);
            cmp("stall_ra_rdy", dramra_rdy, 1);
            cmp("stall_addr", o_dramra, 32'h400);
            step();
        end
        dramra_ack = 1;
        #1 cmp("stall_release_ack", reqa_ack, 3'b010);
        step();
        idle_inputs();
        dramrd_rdy = 1;
        i_rst = 1;
        step();
        i_rst = 0;
        #1;
        cmp("midrst_outst", o_outstanding, 0);
        cmp("midrst_ra_rdy", dramra_rdy, 0);
        cmp("midrst_addr", o_dramra, 0);
        cmp("midrst_rd_ack", dramrd_ack, 0);
        cmp("midrst_rsp_rdy", rsp_rdy, 0);
        step();
        idle_inputs();
        step();

        // Randomized traffic.
        pend = '0; beat_v = 0; beat = '0; last_ack = '0; last_dack = 0;
        for (int i = 0; i < N; i++) paddr[i] = '0;
        for (int c = 0; c < 3000; c++) begin
            drive_rand();
            step();
        end
        i_rst = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
